// File: rtl/data_memory_responder_pkg.sv
// Shared types for the data-memory responder: FSM states and load/store size codes.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package data_memory_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // func3 size codes as used by the core's load/store encoding
    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ls_size_t;

endpackage

// File: rtl/data_memory_responder_load_store_align.sv
// Byte-lane steering for loads/stores: write enables, replicated store word, extended load word.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the parent performs an access.
// Ports: byteOff = addr[1:0], func3 = size code, wData = low-aligned store data,
//        rawWord = RAM word at the access index; byteEn/wWord drive the RAM write,
//        rWord is the extended load result, illegal flags misalignment or an unknown size code.
module load_store_align
    import data_memory_responder_pkg::*;
(
    input  logic [1:0]  byteOff,
    input  logic [2:0]  func3,
    input  logic [31:0] wData,
    input  logic [31:0] rawWord,
    output logic [3:0]  byteEn,
    output logic [31:0] wWord,
    output logic [31:0] rWord,
    output logic        illegal
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    assign laneByte = rawWord[{byteOff, 3'b000} +: 8];
    assign laneHalf = rawWord[{byteOff[1], 4'b0000} +: 16];

    always_comb begin
        byteEn  = 4'b0000;
        wWord   = wData;
        rWord   = '0;
        illegal = 1'b0;
        case (func3)
            LS_B, LS_BU: begin
                // Replicating the byte lets the enable alone pick the lane.
                byteEn = 4'b0001 << byteOff;
                wWord  = {4{wData[7:0]}};
                rWord  = (func3 == LS_B) ? {{24{laneByte[7]}}, laneByte}
                                         : {24'd0, laneByte};
            end
            LS_H, LS_HU: begin
                illegal = byteOff[0];
                byteEn  = byteOff[1] ? 4'b1100 : 4'b0011;
                wWord   = {2{wData[15:0]}};
                rWord   = (func3 == LS_H) ? {{16{laneHalf[15]}}, laneHalf}
                                          : {16'd0, laneHalf};
            end
            LS_W: begin
                illegal = (byteOff != 2'b00);
                byteEn  = 4'b1111;
                rWord   = rawWord;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: owns the data RAM, serves one load/store per request with programmable latency.
// Latency: dMReady/dMOut at cycle T+LATENCY+1 for a request first seen in IDLE at cycle T.
// Backpressure: dMReady low while a request is pending stalls the MEM stage; request held until dMReady.
// Ports: clk/rst (sync, active-high); memRead/memWrite/func3/addr/wData request;
//        dMOut registered load data, dMReady completion/idle, accessError registered illegal-access flag.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DM_MEM_DEPTH = 4096,
    parameter int DATA_WIDTH   = 32,
    parameter int FUNC3_WIDTH  = 3,
    parameter int LATENCY      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   memRead,
    input  logic                   memWrite,
    input  logic [FUNC3_WIDTH-1:0] func3,
    input  logic [DATA_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  wData,
    output logic [DATA_WIDTH-1:0]  dMOut,
    output logic                   dMReady,
    output logic                   accessError
);

    localparam int         IDX_W    = $clog2(DM_MEM_DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    mem_state_t state, nextState;
    logic [3:0] cnt;

    logic [DATA_WIDTH-1:0]  addrQ, wDataQ;
    logic [FUNC3_WIDTH-1:0] func3Q;
    logic                   readQ, writeQ;

    logic request;
    logic doAccess;
    assign request = memRead | memWrite;

    // The IDLE->DONE path (LATENCY == 0) performs the access on the same edge the
    // request is latched, so it must use the live inputs instead of the latches.
    logic                   useLive;
    logic [DATA_WIDTH-1:0]  opAddr, opWData;
    logic [FUNC3_WIDTH-1:0] opFunc3;
    logic                   opRead, opWrite;

    assign useLive = (state == IDLE);
    assign opAddr  = useLive ? addr     : addrQ;
    assign opWData = useLive ? wData    : wDataQ;
    assign opFunc3 = useLive ? func3    : func3Q;
    assign opRead  = useLive ? memRead  : readQ;
    assign opWrite = useLive ? memWrite : writeQ;

    // Upper address bits alias onto the RAM.
    logic unusedAddrBits;
    assign unusedAddrBits = ^opAddr[DATA_WIDTH-1:IDX_W+2];

    logic [31:0]      ram [DM_MEM_DEPTH];
    logic [IDX_W-1:0] wordIdx;
    logic [31:0]      rawWord, wWord, ldWord;
    logic [3:0]       byteEn;
    logic             illegal, opErr;

    assign wordIdx = opAddr[IDX_W+1:2];
    assign rawWord = ram[wordIdx];
    assign opErr   = illegal | (opRead & opWrite);

    load_store_align uAlign (
        .byteOff (opAddr[1:0]),
        .func3   (opFunc3),
        .wData   (opWData),
        .rawWord (rawWord),
        .byteEn  (byteEn),
        .wWord   (wWord),
        .rWord   (ldWord),
        .illegal (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        dMReady   = 1'b0;
        doAccess  = 1'b0;
        case (state)
            IDLE: begin
                dMReady = ~request;
                if (request) begin
                    if (LATENCY == 0) begin
                        nextState = DONE;
                        doAccess  = 1'b1;
                    end else begin
                        nextState = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    nextState = DONE;
                    doAccess  = 1'b1;
                end
            end
            DONE: begin
                dMReady   = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= 4'd0;
            dMOut       <= '0;
            accessError <= 1'b0;
            addrQ       <= '0;
            wDataQ      <= '0;
            func3Q      <= '0;
            readQ       <= 1'b0;
            writeQ      <= 1'b0;
        end else begin
            if (state == IDLE && request) begin
                addrQ  <= addr;
                wDataQ <= wData;
                func3Q <= func3;
                readQ  <= memRead;
                writeQ <= memWrite;
                cnt    <= CNT_INIT;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (doAccess) begin
                accessError <= opErr;
                if (opErr)       dMOut <= '0;
                else if (opRead) dMOut <= ldWord;
            end else if (state == DONE) begin
                accessError <= 1'b0;
            end
        end
    end

    // RAM has no reset; an access coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (doAccess && opWrite && !opErr && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) ram[wordIdx][8*i +: 8] <= wWord[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed steps plus random traffic vs a byte-array model.
// Latency: checks completion at T+LATENCY+1 (LATENCY=2 main instance, LATENCY=0 second instance).
// Backpressure: requests held until dMReady, as the MEM stage does.
module tb_data_memory_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 4096;

    logic        clk, rst;
    logic        memRead, memWrite;
    logic [2:0]  func3;
    logic [31:0] addr, wData, dMOut;
    logic        dMReady, accessError;

    logic        memRead0, memWrite0;
    logic [2:0]  func30;
    logic [31:0] addr0, wData0, dMOut0;
    logic        dMReady0, accessError0;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mdl [DEPTH*4];
    logic [31:0] expOut;

    data_memory_responder #(.DM_MEM_DEPTH(DEPTH), .DATA_WIDTH(32), .FUNC3_WIDTH(3), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .func3(func3),
        .addr(addr), .wData(wData), .dMOut(dMOut), .dMReady(dMReady), .accessError(accessError)
    );

    data_memory_responder #(.DM_MEM_DEPTH(64), .DATA_WIDTH(32), .FUNC3_WIDTH(3), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .memRead(memRead0), .memWrite(memWrite0), .func3(func30),
        .addr(addr0), .wData(wData0), .dMOut(dMOut0), .dMReady(dMReady0), .accessError(accessError0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdlWord(input int byteAddr);
        int b;
        b = byteAddr & ~3;
        return {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
    endfunction

    // Called at a negedge while the DUT is idle; returns at a negedge with the DUT idle again.
    task automatic doAccess(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input string tag);
        int          sz, base, cyc;
        bit          expErr;
        logic [31:0] ld;
        sz     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        expErr = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (rd && wr) || ((a % sz) != 0);
        base   = int'(a % (DEPTH*4));
        if (expErr) begin
            expOut = 32'd0;
        end else if (rd) begin
            ld = 32'd0;
            for (int i = 0; i < sz; i++) ld = ld | (32'(mdl[base+i]) << (8*i));
            if (f3 < 3'd4 && sz < 4 && ld[8*sz-1]) ld = ld | (32'hFFFF_FFFF << (8*sz));
            expOut = ld;
        end else begin
            for (int i = 0; i < sz; i++) mdl[base+i] = 8'(wd >> (8*i));
        end

        memRead = rd; memWrite = wr; func3 = f3; addr = a; wData = wd;
        #1;
        check({tag, "/reqRdy"}, 32'(dMReady), 32'd0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!dMReady && cyc < 40);
        check({tag, "/latency"}, 32'(cyc), 32'(LAT + 1));
        check({tag, "/err"}, 32'(accessError), 32'(expErr));
        check({tag, "/dMOut"}, dMOut, expOut);
        memRead = 1'b0; memWrite = 1'b0;
        @(negedge clk);
        check({tag, "/idleRdy"}, 32'(dMReady), 32'd1);
        check({tag, "/errClr"}, 32'(accessError), 32'd0);
    endtask

    initial begin
        logic [31:0] prior, ra;
        int          r;
        rst = 1'b1;
        memRead = 0; memWrite = 0; func3 = 0; addr = 0; wData = 0;
        memRead0 = 0; memWrite0 = 0; func30 = 0; addr0 = 0; wData0 = 0;
        expOut = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst/dMReady", 32'(dMReady), 32'd1);
        check("rst/dMOut", dMOut, 32'd0);
        check("rst/accessError", 32'(accessError), 32'd0);

        // Give the exercised region known contents.
        for (int w = 0; w < 16; w++) doAccess(0, 1, 3'b010, 32'(w*4), $urandom, "init");

        doAccess(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, "SW10");
        doAccess(1, 0, 3'b010, 32'h10, 32'h0, "LW10");
        check("LW10/const", dMOut, 32'hDEADBEEF);
        doAccess(0, 1, 3'b000, 32'h12, 32'h0000_0080, "SB12");
        doAccess(1, 0, 3'b000, 32'h12, 32'h0, "LB12");
        check("LB12/const", dMOut, 32'hFFFFFF80);
        doAccess(1, 0, 3'b100, 32'h12, 32'h0, "LBU12");
        check("LBU12/const", dMOut, 32'h00000080);
        doAccess(1, 0, 3'b010, 32'h10, 32'h0, "LW10b");
        check("LW10b/const", dMOut, 32'hDE80BEEF);
        doAccess(1, 0, 3'b101, 32'h12, 32'h0, "LHU12");
        check("LHU12/const", dMOut, 32'h0000DE80);
        doAccess(1, 0, 3'b001, 32'h10, 32'h0, "LH10");
        check("LH10/const", dMOut, 32'hFFFFBEEF);
        doAccess(1, 0, 3'b010, 32'h11, 32'h0, "LW11");
        check("LW11/const", dMOut, 32'h0);
        doAccess(0, 1, 3'b010, 32'h11, 32'h12345678, "SW11");
        doAccess(1, 0, 3'b010, 32'h10, 32'h0, "LW10c");
        check("LW10c/const", dMOut, 32'hDE80BEEF);
        doAccess(1, 0, 3'b010, 32'h0010_0010, 32'h0, "LWalias");
        check("LWalias/const", dMOut, 32'hDE80BEEF);

        // Reset while the store is in its final BUSY cycle: the write must be dropped.
        prior = mdlWord(32'h20);
        memWrite = 1'b1; func3 = 3'b010; addr = 32'h20; wData = 32'hFFFFFFFF;
        @(negedge clk);
        check("rstBusy/rdy1", 32'(dMReady), 32'd0);
        @(negedge clk);
        check("rstBusy/rdy2", 32'(dMReady), 32'd0);
        rst = 1'b1; memWrite = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expOut = 32'd0;
        check("rstBusy/idle", 32'(dMReady), 32'd1);
        check("rstBusy/dMOut", dMOut, 32'd0);
        doAccess(1, 0, 3'b010, 32'h20, 32'h0, "LW20");
        check("LW20/prior", dMOut, prior);

        // Random traffic, aliased through the ignored upper address bits.
        for (int n = 0; n < 150; n++) begin
            r  = $urandom_range(0, 5);
            ra = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
            doAccess(r < 3, r >= 3, 3'($urandom_range(0, 7)), ra, $urandom, "rand");
        end

        // LATENCY = 0 instance: completion in the cycle after the request.
        memWrite0 = 1'b1; func30 = 3'b010; addr0 = 32'h8; wData0 = 32'hA5A55A5A;
        #1;
        check("L0sw/reqRdy", 32'(dMReady0), 32'd0);
        @(negedge clk);
        check("L0sw/done", 32'(dMReady0), 32'd1);
        memWrite0 = 1'b0;
        @(negedge clk);
        memRead0 = 1'b1;
        #1;
        check("L0lw/reqRdy", 32'(dMReady0), 32'd0);
        @(negedge clk);
        check("L0lw/done", 32'(dMReady0), 32'd1);
        check("L0lw/dMOut", dMOut0, 32'hA5A55A5A);
        check("L0lw/err", 32'(accessError0), 32'd0);
        memRead0 = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
